// File: rtl/mem_arbiter_if.sv
// Bundle of requester, result and RAM-port signals shared by the byte-RAM arbiter
// and whatever drives it (pipeline stages and RAM model).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mm_req;
  logic              mm_we;
  logic [1:0]        mm_len;
  logic [ADDR_W-1:0] mm_addr;
  logic [31:0]       mm_wdata;
  logic [31:0]       mm_rdata;
  logic              mm_done;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic              stl_if;
  logic              stl_mm;

  modport slave (
    input  if_req, if_addr, if_flush, mm_req, mm_we, mm_len, mm_addr, mm_wdata, ram_dout,
    output if_data, if_done, mm_rdata, mm_done, ram_din, ram_a, ram_wr, stl_if, stl_mm
  );

  modport master (
    output if_req, if_addr, if_flush, mm_req, mm_we, mm_len, mm_addr, mm_wdata, ram_dout,
    input  if_data, if_done, mm_rdata, mm_done, ram_din, ram_a, ram_wr, stl_if, stl_mm
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-RAM arbiter between instruction fetch and the MEM stage; serialises word accesses.
// Optional macro ARB_FAIR_EN: alternate grants on a tie after an MM grant (default: MM always wins).
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int IF_BYTES = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    MM_RD = 2'd2,
    MM_WR = 2'd3
  } state_e;

  localparam logic [2:0]        IF_LEN = 3'(IF_BYTES);
  localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [2:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx[1:0])
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [2:0] idx);
    case (idx[1:0])
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d, len_q, len_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic              ram_wr_q, ram_wr_d;
  logic [31:0]       wdata_q, wdata_d, asm_q, asm_d;
  logic [31:0]       if_data_q, if_data_d, mm_rdata_q, mm_rdata_d;
  logic              if_done_q, if_done_d, mm_done_q, mm_done_d;
  logic              if_ok_s, mm_ok_s, grant_if_s, grant_mm_s;
  logic [2:0]        cnt_inc_s;
`ifdef ARB_FAIR_EN
  logic              last_mm_q, last_mm_d;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      ram_a_q    <= '0;
      ram_din_q  <= 8'd0;
      ram_wr_q   <= 1'b0;
      wdata_q    <= 32'd0;
      asm_q      <= 32'd0;
      if_data_q  <= 32'd0;
      mm_rdata_q <= 32'd0;
      if_done_q  <= 1'b0;
      mm_done_q  <= 1'b0;
`ifdef ARB_FAIR_EN
      last_mm_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ram_a_q    <= ram_a_d;
      ram_din_q  <= ram_din_d;
      ram_wr_q   <= ram_wr_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      if_data_q  <= if_data_d;
      mm_rdata_q <= mm_rdata_d;
      if_done_q  <= if_done_d;
      mm_done_q  <= mm_done_d;
`ifdef ARB_FAIR_EN
      last_mm_q  <= last_mm_d;
`endif
    end
  end

  // Grant decision; a requester whose done pulse is showing holds a stale request.
  always_comb begin
    if_ok_s    = bus.if_req & ~if_done_q & ~bus.if_flush;
    mm_ok_s    = bus.mm_req & ~mm_done_q;
    grant_mm_s = mm_ok_s;
    grant_if_s = if_ok_s & ~mm_ok_s;
`ifdef ARB_FAIR_EN
    if (if_ok_s && mm_ok_s && last_mm_q) begin
      grant_mm_s = 1'b0;
      grant_if_s = 1'b1;
    end else begin
      grant_mm_s = mm_ok_s;
      grant_if_s = if_ok_s & ~mm_ok_s;
    end
`endif
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ram_a_d    = ram_a_q;
    ram_din_d  = ram_din_q;
    ram_wr_d   = 1'b0;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    if_data_d  = if_data_q;
    mm_rdata_d = mm_rdata_q;
    if_done_d  = 1'b0;
    mm_done_d  = 1'b0;
    cnt_inc_s  = cnt_q + 3'd1;
`ifdef ARB_FAIR_EN
    last_mm_d  = last_mm_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_mm_s) begin
          state_d   = bus.mm_we ? MM_WR : MM_RD;
          cnt_d     = 3'd0;
          len_d     = len_bytes(bus.mm_len);
          ram_a_d   = bus.mm_addr;
          wdata_d   = bus.mm_wdata;
          ram_din_d = bus.mm_wdata[7:0];
          ram_wr_d  = bus.mm_we;
          asm_d     = 32'd0;
`ifdef ARB_FAIR_EN
          last_mm_d = 1'b1;
`endif
        end else if (grant_if_s) begin
          state_d   = IF_RD;
          cnt_d     = 3'd0;
          len_d     = IF_LEN;
          ram_a_d   = bus.if_addr;
          asm_d     = 32'd0;
`ifdef ARB_FAIR_EN
          last_mm_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      IF_RD, MM_RD: begin
        if ((state_q == IF_RD) && bus.if_flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s < len_q) ram_a_d = ram_a_q + A_ONE;
          else                   ram_a_d = ram_a_q;
          // RAM data lags its address by one cycle, so byte k lands while cnt = k+1.
          if (cnt_q != 3'd0) asm_d = put_byte(asm_q, cnt_q - 3'd1, bus.ram_dout);
          else               asm_d = asm_q;
          if (cnt_q == len_q) begin
            state_d = IDLE;
            if (state_q == IF_RD) begin
              if_data_d = asm_d;
              if_done_d = 1'b1;
            end else begin
              mm_rdata_d = asm_d;
              mm_done_d  = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
      end
      MM_WR: begin
        if (cnt_q == (len_q - 3'd1)) begin
          state_d   = IDLE;
          mm_done_d = 1'b1;
        end else begin
          cnt_d     = cnt_inc_s;
          ram_a_d   = ram_a_q + A_ONE;
          ram_din_d = get_byte(wdata_q, cnt_inc_s);
          ram_wr_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ram_a    = ram_a_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.ram_wr   = ram_wr_q;
  assign bus.if_data  = if_data_q;
  assign bus.mm_rdata = mm_rdata_q;
  assign bus.if_done  = if_done_q & ~bus.if_flush;
  assign bus.mm_done  = mm_done_q;
  assign bus.stl_if   = bus.if_req & ~bus.if_done;
  assign bus.stl_mm   = bus.mm_req & ~bus.mm_done;

endmodule
